// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type and burst-type tags plus the arbiter state encoding.
package wb_pkg;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEnd     = 3'b111;

    localparam logic [1:0] BteLinear = 2'b00;
    localparam logic [1:0] BteWrap4  = 2'b01;
    localparam logic [1:0] BteWrap8  = 2'b10;
    localparam logic [1:0] BteWrap16 = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1
    } arb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// Counts strobed cycles that have seen no termination; expire_o is high for the single cycle
// in which the count has reached TIMEOUT-1.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q, count_d;

    assign expire_o = (count_q == Limit);

    always_comb begin
        count_d = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin Wishbone arbiter in front of a single SRAM-controller port.
// A grant lasts for the whole of the winner's cyc; a watchdog aborts stalled strobes with err.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wbs0_cyc_i,
    input  logic                  wbs0_stb_i,
    input  logic                  wbs0_we_i,
    input  logic                  wbs0_sel_i,
    input  logic [ADDR_WIDTH-1:0] wbs0_adr_i,
    input  logic [7:0]            wbs0_dat_i,
    input  logic [2:0]            wbs0_cti_i,
    input  logic [1:0]            wbs0_bte_i,
    output logic                  wbs0_ack_o,
    output logic                  wbs0_err_o,
    output logic                  wbs0_rty_o,
    output logic [7:0]            wbs0_dat_o,
    input  logic                  wbs1_cyc_i,
    input  logic                  wbs1_stb_i,
    input  logic                  wbs1_we_i,
    input  logic                  wbs1_sel_i,
    input  logic [ADDR_WIDTH-1:0] wbs1_adr_i,
    input  logic [7:0]            wbs1_dat_i,
    input  logic [2:0]            wbs1_cti_i,
    input  logic [1:0]            wbs1_bte_i,
    output logic                  wbs1_ack_o,
    output logic                  wbs1_err_o,
    output logic                  wbs1_rty_o,
    output logic [7:0]            wbs1_dat_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic                  wbm_sel_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [7:0]            wbm_dat_o,
    output logic [2:0]            wbm_cti_o,
    output logic [1:0]            wbm_bte_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic                  wbm_rty_i,
    input  logic [7:0]            wbm_dat_i
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;

    logic gnt1, granted, req_cyc, req_stb, req_we, term;
    logic wd_en, wd_clear, wd_expire, expire;
    logic ack_req, err_req, rty_req;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (wbs0_cyc_i && wbs1_cyc_i) begin
                    state_d = last_grant_q ? StGnt0 : StGnt1;
                end else if (wbs0_cyc_i) begin
                    state_d = StGnt0;
                end else if (wbs1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!wbs0_cyc_i) begin
                    last_grant_d = 1'b0;
                    state_d      = wbs1_cyc_i ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (!wbs1_cyc_i) begin
                    last_grant_d = 1'b1;
                    state_d      = wbs0_cyc_i ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Gating with rst_i drops the bus in the reset cycle itself, even if state_q still holds a grant.
    assign gnt1    = (state_q == StGnt1);
    assign granted = !rst_i && (state_q != StIdle);
    assign req_cyc = gnt1 ? wbs1_cyc_i : wbs0_cyc_i;
    assign req_stb = gnt1 ? wbs1_stb_i : wbs0_stb_i;
    assign req_we  = gnt1 ? wbs1_we_i  : wbs0_we_i;
    assign term    = wbm_ack_i || wbm_err_i || wbm_rty_i;

    assign wd_en    = granted && req_stb && !term;
    assign wd_clear = term || !granted || (state_d != state_q);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (wd_clear),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    assign expire = granted && wd_expire;

    assign wbm_cyc_o = granted && req_cyc && !expire;
    assign wbm_stb_o = granted && req_stb && !expire;
    assign wbm_we_o  = granted && req_we;
    assign wbm_sel_o = gnt1 ? wbs1_sel_i : wbs0_sel_i;
    assign wbm_adr_o = gnt1 ? wbs1_adr_i : wbs0_adr_i;
    assign wbm_dat_o = gnt1 ? wbs1_dat_i : wbs0_dat_i;
    assign wbm_cti_o = gnt1 ? wbs1_cti_i : wbs0_cti_i;
    assign wbm_bte_o = gnt1 ? wbs1_bte_i : wbs0_bte_i;

    // A real ack arriving in the expiry cycle wins over the synthesized err.
    assign ack_req = granted && wbm_ack_i;
    assign err_req = granted && (expire ? !wbm_ack_i : wbm_err_i);
    assign rty_req = granted && wbm_rty_i;

    assign wbs0_ack_o = ack_req && !gnt1;
    assign wbs0_err_o = err_req && !gnt1;
    assign wbs0_rty_o = rty_req && !gnt1;
    assign wbs1_ack_o = ack_req && gnt1;
    assign wbs1_err_o = err_req && gnt1;
    assign wbs1_rty_o = rty_req && gnt1;

    assign wbs0_dat_o = wbm_dat_i;
    assign wbs1_dat_o = wbm_dat_i;

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 23, sets the Wishbone address width on all ports.
REQ-002 Parameter TIMEOUT, default 255, is the maximum number of cycles a strobed cycle may wait for ack/err/rty; minimum legal value 2.
REQ-003 Port clk_i, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1: synchronous, active-high reset.
REQ-005 Ports wbsN_cyc_i, wbsN_stb_i, wbsN_we_i, wbsN_sel_i (N=0,1), input, 1 each: requester N bus-cycle controls.
REQ-006 Ports wbsN_adr_i input ADDR_WIDTH, wbsN_dat_i input 8, wbsN_cti_i input 3, wbsN_bte_i input 2: requester N address, write data and burst tags.
REQ-007 Ports wbsN_ack_o, wbsN_err_o, wbsN_rty_o, output, 1 each: requester N terminations.
REQ-008 Port wbsN_dat_o, output, 8: requester N read data.
REQ-009 Ports wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o output 1; wbm_adr_o output ADDR_WIDTH; wbm_dat_o output 8; wbm_cti_o output 3; wbm_bte_o output 2: shared SRAM-controller port.
REQ-010 Ports wbm_ack_i, wbm_err_i, wbm_rty_i input 1; wbm_dat_i input 8: SRAM-controller terminations and read data.

Function
REQ-011 FSM states: IDLE, GNT0, GNT1; registered state, registered last_grant bit.
REQ-012 IDLE: only wbs0_cyc_i -> GNT0; only wbs1_cyc_i -> GNT1; both -> grant the port not equal to last_grant; neither -> stay IDLE.
REQ-013 Grant latency: exactly one cycle from cyc_i assertion in IDLE to wbm_cyc_o assertion.
REQ-014 In GNTn: wbm_cyc_o/stb_o = wbsn_cyc_i/stb_i; wbm_adr/dat/we/sel/cti/bte driven from port n combinationally.
REQ-015 In GNTn: wbsn_ack/err/rty_o = wbm_ack/err/rty_i; the other port's ack/err/rty_o held 0.
REQ-016 wbs0_dat_o and wbs1_dat_o both = wbm_dat_i at all times.
REQ-017 In IDLE: wbm_cyc_o=wbm_stb_o=wbm_we_o=0; other wbm outputs don't-care but stable (port 0 mux).
REQ-018 Grant held for the whole of wbsn_cyc_i regardless of cti (bursts and multi-transfer cycles never split).
REQ-019 GNTn with wbsn_cyc_i=0: if other port's cyc_i=1 -> GNT(other) next cycle, else IDLE; last_grant<=n on every release.
REQ-020 Watchdog: 8-bit-wide-enough counter increments each GNTn cycle with wbm_stb_o=1 and no ack/err/rty; clears on any termination or grant change.
REQ-021 Counter reaching TIMEOUT-1: next cycle wbsn_err_o=1 for one cycle, wbm_cyc_o/stb_o forced 0 that cycle, counter cleared, grant retained.
REQ-022 Simultaneous wbm_ack_i and watchdog expiry: ack wins, no err issued.
REQ-023 wbm_err_i/rty_i pass through unchanged; they do not release the grant.

Reset
REQ-024 On rst_i=1: state<=IDLE, last_grant<=1 (port 0 wins first contention), counter<=0.
REQ-025 During and the cycle after reset: wbm_cyc_o=wbm_stb_o=0, all wbsN_ack/err/rty_o=0.
REQ-026 Reset mid-cycle: bus dropped at next edge; no termination delivered to the interrupted requester.

Structure
REQ-027 Shared package wb_pkg holds CTI codes (classic 000, incr 010, end 111), BTE codes and the arbiter state enum.
REQ-028 Watchdog is sub-module wb_watchdog (clear, count-enable, expire pulse, parameter TIMEOUT).
REQ-029 Implementation is purely synchronous; only muxes combinational.

Verification
REQ-030 Port 0 single read adr 0x000010, ack after 3 cycles -> wbm_cyc_o rises 1 cycle after wbs0_cyc_i, wbs0_ack_o 1 cycle, wbs1 outputs 0.
REQ-031 Both cyc_i rise together after reset -> GNT0 first; both again after release -> GNT1; third contention -> GNT0.
REQ-032 Port 1 incr burst 4 bytes (cti 010,010,010,111) while port 0 requests -> port 1 keeps grant for all 4 acks, port 0 granted the cycle after wbs1_cyc_i falls.
REQ-033 TIMEOUT=8, slave never acks -> wbs0_err_o pulse at 8th strobed cycle, wbm_cyc_o low that cycle, no ack on wbs1.
REQ-034 Assert rst_i during port 1 write -> wbm_cyc_o 0 next cycle, state IDLE, next contention grants port 0.
